// File: rtl/rx_vctr_pkg.sv
// Shared types and constants for the receive-vector collector.
// Header bytes precede the direction-flag rise and are dropped by the collector.
package rx_vctr_pkg;

  typedef enum logic [1:0] {
    StIdle,
    StColOut,
    StColIn
  } state_e;

  localparam logic [7:0]  HDR_OUT     = 8'hA5;
  localparam logic [7:0]  HDR_IN      = 8'h00;
  localparam int unsigned NBYTES_DEF  = 4;
  localparam int unsigned TIMEOUT_DEF = 32768;

endpackage

// File: rtl/rx_vctr_collect_if.sv
// Byte-in / vector-out bundle between the UART receiver, the collector and the channel consumer.
// master drives the receiver-side inputs and the consumer ack; slave is the collector.
interface rx_vctr_collect_if #(
  parameter int unsigned NBYTES = 4
);
  logic [7:0]          rx_data;
  logic                rx_valid;
  logic                vctr_out;
  logic                vctr_in;
  logic                rx_ch_comp;
  logic [NBYTES*8-1:0] vctr_out_data;
  logic [NBYTES*8-1:0] vctr_in_data;
  logic                rx_vctr_comp_out;
  logic                rx_vctr_comp_in;
  logic                vctr_valid;
  logic                err_timeout;
  logic                err_abort;
  logic                err_overrun;

  modport master (
    output rx_data, rx_valid, vctr_out, vctr_in, rx_ch_comp,
    input  vctr_out_data, vctr_in_data, rx_vctr_comp_out, rx_vctr_comp_in,
    input  vctr_valid, err_timeout, err_abort, err_overrun
  );

  modport slave (
    input  rx_data, rx_valid, vctr_out, vctr_in, rx_ch_comp,
    output vctr_out_data, vctr_in_data, rx_vctr_comp_out, rx_vctr_comp_in,
    output vctr_valid, err_timeout, err_abort, err_overrun
  );
endinterface

// File: rtl/rx_vctr_timer.sv
// Inactivity counter: counts while enabled, clears on request, flags the TIMEOUT-th idle clock.
module rx_vctr_timer #(
  parameter int unsigned TIMEOUT = 32768,
  parameter int unsigned TO_W    = 16
) (
  input  logic clock,
  input  logic rst,
  input  logic clr,
  input  logic en,
  output logic expire
);

  logic [TO_W-1:0] cnt_q;

  // A clear on the expiry cycle (byte arrival) suppresses expiry.
  assign expire = en && !clr && (cnt_q == TO_W'(TIMEOUT - 1));

  always_ff @(posedge clock or posedge rst) begin
    if (rst) begin
      cnt_q <= '0;
    end else if (clr) begin
      cnt_q <= '0;
    end else if (en) begin
      cnt_q <= cnt_q + 1'b1;
    end
  end

endmodule

// File: rtl/rx_vctr_collect.sv
// Packs received payload bytes into OUT/IN vectors, tracks completion flags until the
// channel consumer acknowledges, and reports timeout, abort and overrun errors.
module rx_vctr_collect
  import rx_vctr_pkg::*;
#(
  parameter int unsigned NBYTES  = NBYTES_DEF,
  parameter int unsigned TIMEOUT = TIMEOUT_DEF,
  parameter int unsigned TO_W    = 16
) (
  input logic               clock,
  input logic               rst,
  rx_vctr_collect_if.slave  bus
);

  localparam int unsigned VW   = NBYTES * 8;
  localparam int unsigned IdxW = (NBYTES > 1) ? $clog2(NBYTES) : 1;

  state_e          state_q, state_d;
  logic [IdxW-1:0] idx_q, idx_d;
  logic [VW-1:0]   shift_q, shift_d;
  logic [VW-1:0]   out_data_q, out_data_d;
  logic [VW-1:0]   in_data_q, in_data_d;
  logic            comp_out_q, comp_out_d;
  logic            comp_in_q, comp_in_d;
  logic            fired_q, fired_d;
  logic            vctr_valid_q, vctr_valid_d;
  logic            err_timeout_q, err_timeout_d;
  logic            err_abort_q, err_abort_d;
  logic            err_overrun_q, err_overrun_d;
  logic            set_out, set_in, dir_flag;
  logic            timer_clr, timer_en, timer_expire;

  assign timer_clr = (state_q == StIdle) || bus.rx_valid;
  assign timer_en  = (state_q != StIdle);

  rx_vctr_timer #(
    .TIMEOUT (TIMEOUT),
    .TO_W    (TO_W)
  ) u_timer (
    .clock  (clock),
    .rst    (rst),
    .clr    (timer_clr),
    .en     (timer_en),
    .expire (timer_expire)
  );

  always_comb begin
    state_d       = state_q;
    idx_d         = idx_q;
    shift_d       = shift_q;
    out_data_d    = out_data_q;
    in_data_d     = in_data_q;
    err_timeout_d = 1'b0;
    err_abort_d   = 1'b0;
    set_out       = 1'b0;
    set_in        = 1'b0;
    dir_flag      = 1'b0;

    unique case (state_q)
      StIdle: begin
        idx_d   = '0;
        shift_d = '0;
        if (bus.vctr_out) begin
          state_d = StColOut;
        end else if (bus.vctr_in) begin
          state_d = StColIn;
        end
      end
      StColOut, StColIn: begin
        dir_flag = (state_q == StColOut) ? bus.vctr_out : bus.vctr_in;
        if (!dir_flag) begin
          err_abort_d = 1'b1;
          state_d     = StIdle;
        end else if (bus.rx_valid) begin
          shift_d[8*idx_q +: 8] = bus.rx_data;
          if (idx_q == IdxW'(NBYTES - 1)) begin
            state_d = StIdle;
            if (state_q == StColOut) begin
              out_data_d = shift_d;
              set_out    = 1'b1;
            end else begin
              in_data_d = shift_d;
              set_in    = 1'b1;
            end
          end else begin
            idx_d = idx_q + 1'b1;
          end
        end else if (timer_expire) begin
          err_timeout_d = 1'b1;
          state_d       = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase

    // A completion wins over the ack for its own vector only.
    comp_out_d    = set_out | (comp_out_q & ~bus.rx_ch_comp);
    comp_in_d     = set_in | (comp_in_q & ~bus.rx_ch_comp);
    err_overrun_d = (set_out & comp_out_q) | (set_in & comp_in_q);
    vctr_valid_d  = comp_out_d & comp_in_d & ~fired_q;
    // fired blocks a repeat pulse until both flags have been released.
    if (comp_out_d && comp_in_d) begin
      fired_d = 1'b1;
    end else if (!comp_out_d && !comp_in_d) begin
      fired_d = 1'b0;
    end else begin
      fired_d = fired_q;
    end
  end

  always_ff @(posedge clock or posedge rst) begin
    if (rst) begin
      state_q       <= StIdle;
      idx_q         <= '0;
      shift_q       <= '0;
      out_data_q    <= '0;
      in_data_q     <= '0;
      comp_out_q    <= 1'b0;
      comp_in_q     <= 1'b0;
      fired_q       <= 1'b0;
      vctr_valid_q  <= 1'b0;
      err_timeout_q <= 1'b0;
      err_abort_q   <= 1'b0;
      err_overrun_q <= 1'b0;
    end else begin
      state_q       <= state_d;
      idx_q         <= idx_d;
      shift_q       <= shift_d;
      out_data_q    <= out_data_d;
      in_data_q     <= in_data_d;
      comp_out_q    <= comp_out_d;
      comp_in_q     <= comp_in_d;
      fired_q       <= fired_d;
      vctr_valid_q  <= vctr_valid_d;
      err_timeout_q <= err_timeout_d;
      err_abort_q   <= err_abort_d;
      err_overrun_q <= err_overrun_d;
    end
  end

  assign bus.vctr_out_data    = out_data_q;
  assign bus.vctr_in_data     = in_data_q;
  assign bus.rx_vctr_comp_out = comp_out_q;
  assign bus.rx_vctr_comp_in  = comp_in_q;
  assign bus.vctr_valid       = vctr_valid_q;
  assign bus.err_timeout      = err_timeout_q;
  assign bus.err_abort        = err_abort_q;
  assign bus.err_overrun      = err_overrun_q;

endmodule

// File: tb/tb_rx_vctr_collect.sv
// Directed bench for rx_vctr_collect: collection, ack, timeout, abort, overrun, priority, reset.
module tb_rx_vctr_collect;
  import rx_vctr_pkg::*;

  localparam int unsigned NB  = 4;
  localparam int unsigned TMO = 32768;

  logic clock;
  logic rst;
  int   n_cmp;
  int   n_err;

  rx_vctr_collect_if #(.NBYTES(NB)) bus ();

  rx_vctr_collect #(
    .NBYTES  (NB),
    .TIMEOUT (TMO),
    .TO_W    (16)
  ) dut (
    .clock (clock),
    .rst   (rst),
    .bus   (bus)
  );

  initial begin
    clock = 1'b0;
    forever #5 clock = ~clock;
  end

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic send_byte(input logic [7:0] b);
    bus.rx_data  = b;
    bus.rx_valid = 1'b1;
    step();
    bus.rx_valid = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (2) step();
    n_cmp++; if (bus.vctr_out_data !== 32'h0) begin n_err++; $display("FAIL rst_out_data got %h want %h", bus.vctr_out_data, 32'h0); end
    n_cmp++; if (bus.vctr_in_data !== 32'h0) begin n_err++; $display("FAIL rst_in_data got %h want %h", bus.vctr_in_data, 32'h0); end
    n_cmp++; if ({bus.rx_vctr_comp_out, bus.rx_vctr_comp_in, bus.vctr_valid} !== 3'b000) begin n_err++; $display("FAIL rst_flags got %b want 000", {bus.rx_vctr_comp_out, bus.rx_vctr_comp_in, bus.vctr_valid}); end
    n_cmp++; if ({bus.err_timeout, bus.err_abort, bus.err_overrun} !== 3'b000) begin n_err++; $display("FAIL rst_errs got %b want 000", {bus.err_timeout, bus.err_abort, bus.err_overrun}); end
    rst = 1'b0;
    step();
  endtask

  task automatic test_out_collect();
    send_byte(HDR_OUT);
    bus.vctr_out = 1'b1;
    step();
    send_byte(8'h11); send_byte(8'h22); send_byte(8'h33); send_byte(8'h44);
    bus.vctr_out = 1'b0;
    n_cmp++; if (bus.vctr_out_data !== 32'h44332211) begin n_err++; $display("FAIL out_data got %h want %h", bus.vctr_out_data, 32'h44332211); end
    n_cmp++; if (bus.rx_vctr_comp_out !== 1'b1) begin n_err++; $display("FAIL out_comp got %b want 1", bus.rx_vctr_comp_out); end
    n_cmp++; if (bus.vctr_valid !== 1'b0) begin n_err++; $display("FAIL out_vvalid got %b want 0", bus.vctr_valid); end
    n_cmp++; if (bus.rx_vctr_comp_in !== 1'b0) begin n_err++; $display("FAIL out_comp_in got %b want 0", bus.rx_vctr_comp_in); end
  endtask

  task automatic test_in_collect_ack();
    send_byte(HDR_IN);
    bus.vctr_in = 1'b1;
    step();
    send_byte(8'hAA); send_byte(8'hBB); send_byte(8'hCC); send_byte(8'hDD);
    bus.vctr_in = 1'b0;
    n_cmp++; if (bus.vctr_in_data !== 32'hDDCCBBAA) begin n_err++; $display("FAIL in_data got %h want %h", bus.vctr_in_data, 32'hDDCCBBAA); end
    n_cmp++; if (bus.rx_vctr_comp_in !== 1'b1) begin n_err++; $display("FAIL in_comp got %b want 1", bus.rx_vctr_comp_in); end
    n_cmp++; if (bus.vctr_valid !== 1'b1) begin n_err++; $display("FAIL in_vvalid_hi got %b want 1", bus.vctr_valid); end
    step();
    n_cmp++; if (bus.vctr_valid !== 1'b0) begin n_err++; $display("FAIL in_vvalid_lo got %b want 0", bus.vctr_valid); end
    bus.rx_ch_comp = 1'b1;
    step();
    bus.rx_ch_comp = 1'b0;
    n_cmp++; if ({bus.rx_vctr_comp_out, bus.rx_vctr_comp_in} !== 2'b00) begin n_err++; $display("FAIL ack_flags got %b want 00", {bus.rx_vctr_comp_out, bus.rx_vctr_comp_in}); end
    n_cmp++; if (bus.vctr_out_data !== 32'h44332211) begin n_err++; $display("FAIL ack_out_hold got %h want %h", bus.vctr_out_data, 32'h44332211); end
    n_cmp++; if (bus.vctr_in_data !== 32'hDDCCBBAA) begin n_err++; $display("FAIL ack_in_hold got %h want %h", bus.vctr_in_data, 32'hDDCCBBAA); end
    step();
    n_cmp++; if (bus.vctr_valid !== 1'b0) begin n_err++; $display("FAIL ack_vvalid got %b want 0", bus.vctr_valid); end
  endtask

  task automatic test_timeout();
    bus.vctr_out = 1'b1;
    step();
    send_byte(8'h01); send_byte(8'h02);
    repeat (TMO - 1) step();
    n_cmp++; if (bus.err_timeout !== 1'b0) begin n_err++; $display("FAIL to_early got %b want 0", bus.err_timeout); end
    step();
    bus.vctr_out = 1'b0;
    n_cmp++; if (bus.err_timeout !== 1'b1) begin n_err++; $display("FAIL to_pulse got %b want 1", bus.err_timeout); end
    n_cmp++; if (dut.state_q !== StIdle) begin n_err++; $display("FAIL to_state got %0d want %0d", dut.state_q, StIdle); end
    n_cmp++; if (bus.rx_vctr_comp_out !== 1'b0) begin n_err++; $display("FAIL to_comp got %b want 0", bus.rx_vctr_comp_out); end
    n_cmp++; if (bus.vctr_out_data !== 32'h44332211) begin n_err++; $display("FAIL to_data got %h want %h", bus.vctr_out_data, 32'h44332211); end
    step();
    n_cmp++; if (bus.err_timeout !== 1'b0) begin n_err++; $display("FAIL to_one_clk got %b want 0", bus.err_timeout); end
  endtask

  task automatic test_abort();
    bus.vctr_in = 1'b1;
    step();
    send_byte(8'h01); send_byte(8'h02); send_byte(8'h03);
    bus.vctr_in = 1'b0;
    step();
    n_cmp++; if (bus.err_abort !== 1'b1) begin n_err++; $display("FAIL abort_pulse got %b want 1", bus.err_abort); end
    step();
    n_cmp++; if (bus.err_abort !== 1'b0) begin n_err++; $display("FAIL abort_one_clk got %b want 0", bus.err_abort); end
    bus.vctr_in = 1'b1;
    step();
    send_byte(8'h55); send_byte(8'h66); send_byte(8'h77); send_byte(8'h88);
    bus.vctr_in = 1'b0;
    n_cmp++; if (bus.vctr_in_data !== 32'h88776655) begin n_err++; $display("FAIL abort_next got %h want %h", bus.vctr_in_data, 32'h88776655); end
    n_cmp++; if (bus.rx_vctr_comp_in !== 1'b1) begin n_err++; $display("FAIL abort_next_comp got %b want 1", bus.rx_vctr_comp_in); end
    n_cmp++; if (bus.err_overrun !== 1'b0) begin n_err++; $display("FAIL abort_no_ovr got %b want 0", bus.err_overrun); end
  endtask

  task automatic test_overrun();
    bus.vctr_in = 1'b1;
    step();
    send_byte(8'h12); send_byte(8'h34); send_byte(8'h56); send_byte(8'h78);
    bus.vctr_in = 1'b0;
    n_cmp++; if (bus.err_overrun !== 1'b1) begin n_err++; $display("FAIL ovr_pulse got %b want 1", bus.err_overrun); end
    n_cmp++; if (bus.vctr_in_data !== 32'h78563412) begin n_err++; $display("FAIL ovr_data got %h want %h", bus.vctr_in_data, 32'h78563412); end
    n_cmp++; if (bus.rx_vctr_comp_in !== 1'b1) begin n_err++; $display("FAIL ovr_comp got %b want 1", bus.rx_vctr_comp_in); end
    n_cmp++; if (bus.vctr_valid !== 1'b0) begin n_err++; $display("FAIL ovr_vvalid got %b want 0", bus.vctr_valid); end
    bus.rx_ch_comp = 1'b1;
    step();
    bus.rx_ch_comp = 1'b0;
    n_cmp++; if (bus.err_overrun !== 1'b0) begin n_err++; $display("FAIL ovr_one_clk got %b want 0", bus.err_overrun); end
  endtask

  task automatic test_priority_ack_race();
    bus.vctr_out = 1'b1;
    bus.vctr_in  = 1'b1;
    step();
    send_byte(8'hA1); send_byte(8'hA2); send_byte(8'hA3); send_byte(8'hA4);
    bus.vctr_out = 1'b0;
    n_cmp++; if (bus.vctr_out_data !== 32'hA4A3A2A1) begin n_err++; $display("FAIL prio_out got %h want %h", bus.vctr_out_data, 32'hA4A3A2A1); end
    n_cmp++; if ({bus.rx_vctr_comp_out, bus.rx_vctr_comp_in} !== 2'b10) begin n_err++; $display("FAIL prio_flags got %b want 10", {bus.rx_vctr_comp_out, bus.rx_vctr_comp_in}); end
    step();
    send_byte(8'hB1); send_byte(8'hB2); send_byte(8'hB3);
    bus.rx_ch_comp = 1'b1;
    send_byte(8'hB4);
    bus.rx_ch_comp = 1'b0;
    bus.vctr_in    = 1'b0;
    n_cmp++; if ({bus.rx_vctr_comp_out, bus.rx_vctr_comp_in} !== 2'b01) begin n_err++; $display("FAIL race_flags got %b want 01", {bus.rx_vctr_comp_out, bus.rx_vctr_comp_in}); end
    n_cmp++; if (bus.vctr_in_data !== 32'hB4B3B2B1) begin n_err++; $display("FAIL race_in got %h want %h", bus.vctr_in_data, 32'hB4B3B2B1); end
    n_cmp++; if (bus.vctr_valid !== 1'b0) begin n_err++; $display("FAIL race_vvalid got %b want 0", bus.vctr_valid); end
    n_cmp++; if (bus.vctr_out_data !== 32'hA4A3A2A1) begin n_err++; $display("FAIL race_out_hold got %h want %h", bus.vctr_out_data, 32'hA4A3A2A1); end
  endtask

  task automatic test_async_reset();
    bus.vctr_out = 1'b1;
    step();
    send_byte(8'hE1); send_byte(8'hE2);
    rst = 1'b1;
    #2;
    n_cmp++; if (bus.vctr_out_data !== 32'h0) begin n_err++; $display("FAIL arst_out got %h want %h", bus.vctr_out_data, 32'h0); end
    n_cmp++; if (bus.vctr_in_data !== 32'h0) begin n_err++; $display("FAIL arst_in got %h want %h", bus.vctr_in_data, 32'h0); end
    n_cmp++; if (bus.rx_vctr_comp_in !== 1'b0) begin n_err++; $display("FAIL arst_comp got %b want 0", bus.rx_vctr_comp_in); end
    n_cmp++; if (dut.state_q !== StIdle) begin n_err++; $display("FAIL arst_state got %0d want %0d", dut.state_q, StIdle); end
    rst = 1'b0;
    step();
    send_byte(8'hC1); send_byte(8'hC2); send_byte(8'hC3); send_byte(8'hC4);
    bus.vctr_out = 1'b0;
    n_cmp++; if (bus.vctr_out_data !== 32'hC4C3C2C1) begin n_err++; $display("FAIL arst_next got %h want %h", bus.vctr_out_data, 32'hC4C3C2C1); end
    n_cmp++; if (bus.rx_vctr_comp_out !== 1'b1) begin n_err++; $display("FAIL arst_next_comp got %b want 1", bus.rx_vctr_comp_out); end
  endtask

  initial begin
    n_cmp          = 0;
    n_err          = 0;
    rst            = 1'b1;
    bus.rx_data    = 8'h00;
    bus.rx_valid   = 1'b0;
    bus.vctr_out   = 1'b0;
    bus.vctr_in    = 1'b0;
    bus.rx_ch_comp = 1'b0;
    test_reset();
    test_out_collect();
    test_in_collect_ack();
    test_timeout();
    test_abort();
    test_overrun();
    test_priority_ack_race();
    test_async_reset();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
